spi_cfg_master: RTL and testbench

SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

---
 rtl/spi_cfg_pkg.sv | 24 ++
 rtl/spi_cfg_master_if.sv | 13 +
 rtl/cfg_fifo.sv | 46 ++++
 rtl/spi_cfg_master.sv | 143 ++++++++++++++
 tb/tb_spi_cfg_master.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI sensor-configuration master.
package spi_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CLK_LO,
      ST_CLK_HI,
      ST_LATCH,
      ST_GAP
   } state_e;

   // LUPA sensor register map
   localparam int unsigned LUPA_ADDR_W = 4;
   localparam logic [LUPA_ADDR_W-1:0] REG_SEQUENCER   = 4'h0;
   localparam logic [LUPA_ADDR_W-1:0] REG_START1      = 4'h1;
   localparam logic [LUPA_ADDR_W-1:0] REG_START2      = 4'h2;
   localparam logic [LUPA_ADDR_W-1:0] REG_START3      = 4'h3;
   localparam logic [LUPA_ADDR_W-1:0] REG_RES1_LENGTH = 4'h4;
   localparam logic [LUPA_ADDR_W-1:0] REG_RES2_TIMER  = 4'h5;
   localparam logic [LUPA_ADDR_W-1:0] REG_RES3_TIMER  = 4'h6;
   localparam logic [LUPA_ADDR_W-1:0] REG_FT_TIMER    = 4'h7;

endpackage

// File: rtl/spi_cfg_master_if.sv
// Register-write request channel (valid/ready handshake) into the SPI config master.
interface spi_cfg_master_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 12
);
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
   modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/cfg_fifo.sv
// Small power-of-two FIFO; caller guarantees no push when full (unless popping) and no pop when empty.
module cfg_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset; the count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= push_data;
   end

   assign head  = mem[rd_ptr_q];
   assign count = cnt_q;
endmodule

// File: rtl/spi_cfg_master.sv
// Queues sensor register writes and shifts each {addr,data} word out MSB first,
// latching it with an spi_en pulse; new words never start while fval is high.
module spi_cfg_master import spi_cfg_pkg::*; #(
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned DATA_W     = 12,
   parameter int unsigned CLK_DIV    = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic             clock_20,
   input  logic             reset_n,
   spi_cfg_master_if.slave  wr,
   input  logic             fval,
   output logic             spi_clk,
   output logic             spi_en,
   output logic             spi_dat,
   output logic             busy,
   output logic             word_done,
   output logic             ovf
);
   localparam int unsigned N     = ADDR_W + DATA_W;
   localparam int unsigned HP_W  = $clog2(CLK_DIV + 1);
   localparam int unsigned BIT_W = $clog2(N + 1);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   state_e           state_q, state_d;
   logic [HP_W-1:0]  hp_cnt_q, hp_cnt_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [N-1:0]     shreg_q, shreg_d;
   logic             spi_clk_q, spi_clk_d, spi_en_q, spi_en_d, spi_dat_q, spi_dat_d;
   logic             busy_q, busy_d, word_done_q, word_done_d, ovf_q, ovf_d;
   logic             wr_ready_q, wr_ready_d;

   logic             push, pop, hp_last;
   logic [N-1:0]     fifo_head;
   logic [CNT_W-1:0] fifo_cnt, cnt_nxt;

   assign push    = wr.wr_valid && wr_ready_q;
   assign pop     = (state_q == ST_LOAD);
   assign hp_last = (hp_cnt_q == HP_W'(CLK_DIV - 1));

   cfg_fifo #(.WIDTH(N), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clock_20),
      .rst_n     (reset_n),
      .push      (push),
      .push_data ({wr.wr_addr, wr.wr_data}),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_cnt)
   );

   always_ff @(posedge clock_20 or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next state plus the half-period / bit counters and shift register.
   always_comb begin
      state_d   = state_q;
      hp_cnt_d  = hp_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      case (state_q)
         ST_IDLE: if (fifo_cnt != '0 && !fval) state_d = ST_LOAD;
         ST_LOAD: begin
            shreg_d   = fifo_head;
            bit_cnt_d = '0;
            hp_cnt_d  = '0;
            state_d   = ST_CLK_LO;
         end
         ST_CLK_LO: begin
            hp_cnt_d = hp_last ? '0 : hp_cnt_q + HP_W'(1);
            if (hp_last) state_d = ST_CLK_HI;
         end
         ST_CLK_HI: begin
            hp_cnt_d = hp_last ? '0 : hp_cnt_q + HP_W'(1);
            if (hp_last) begin
               if (bit_cnt_q == BIT_W'(N - 1)) begin
                  state_d = ST_LATCH;
               end else begin
                  shreg_d   = shreg_q << 1;
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  state_d   = ST_CLK_LO;
               end
            end
         end
         ST_LATCH: begin
            hp_cnt_d = hp_last ? '0 : hp_cnt_q + HP_W'(1);
            if (hp_last) state_d = ST_GAP;
         end
         ST_GAP: begin
            hp_cnt_d = hp_last ? '0 : hp_cnt_q + HP_W'(1);
            if (hp_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered pins line up with the state.
   always_comb begin
      cnt_nxt     = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      spi_clk_d   = (state_d == ST_CLK_HI);
      spi_en_d    = (state_d == ST_LATCH);
      spi_dat_d   = (state_d == ST_CLK_LO || state_d == ST_CLK_HI) ? shreg_d[N-1] : 1'b0;
      word_done_d = (state_d == ST_LATCH) && (hp_cnt_d == HP_W'(CLK_DIV - 1));
      busy_d      = (state_d != ST_IDLE) || (cnt_nxt != '0);
      wr_ready_d  = (cnt_nxt != CNT_W'(FIFO_DEPTH)) || (state_d == ST_LOAD);
      ovf_d       = ovf_q || (wr.wr_valid && !wr_ready_q);
   end

   always_ff @(posedge clock_20 or negedge reset_n) begin
      if (!reset_n) begin
         hp_cnt_q    <= '0;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         spi_clk_q   <= 1'b0;
         spi_en_q    <= 1'b0;
         spi_dat_q   <= 1'b0;
         busy_q      <= 1'b0;
         word_done_q <= 1'b0;
         ovf_q       <= 1'b0;
         wr_ready_q  <= 1'b0;
      end else begin
         hp_cnt_q    <= hp_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         spi_clk_q   <= spi_clk_d;
         spi_en_q    <= spi_en_d;
         spi_dat_q   <= spi_dat_d;
         busy_q      <= busy_d;
         word_done_q <= word_done_d;
         ovf_q       <= ovf_d;
         wr_ready_q  <= wr_ready_d;
      end
   end

   assign spi_clk     = spi_clk_q;
   assign spi_en      = spi_en_q;
   assign spi_dat     = spi_dat_q;
   assign busy        = busy_q;
   assign word_done   = word_done_q;
   assign ovf         = ovf_q;
   assign wr.wr_ready = wr_ready_q;
endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench: default instance (16-bit words, CLK_DIV=1) and a CLK_DIV=3, 20-bit instance.
module tb_spi_cfg_master;
   import spi_cfg_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic fval0, fval1;
   logic sclk0, sen0, sdat0, busy0, wdone0, ovf0;
   logic sclk1, sen1, sdat1, busy1, wdone1, ovf1;
   int   cyc = 0;
   int   n_chk = 0, n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_cfg_master_if #(.ADDR_W(4), .DATA_W(12)) if0 ();
   spi_cfg_master_if #(.ADDR_W(4), .DATA_W(16)) if1 ();

   spi_cfg_master #(.ADDR_W(4), .DATA_W(12), .CLK_DIV(1), .FIFO_DEPTH(4)) dut0 (
      .clock_20(clk), .reset_n(rst_n), .wr(if0), .fval(fval0),
      .spi_clk(sclk0), .spi_en(sen0), .spi_dat(sdat0),
      .busy(busy0), .word_done(wdone0), .ovf(ovf0));

   spi_cfg_master #(.ADDR_W(4), .DATA_W(16), .CLK_DIV(3), .FIFO_DEPTH(4)) dut1 (
      .clock_20(clk), .reset_n(rst_n), .wr(if1), .fval(fval1),
      .spi_clk(sclk1), .spi_en(sen1), .spi_dat(sdat1),
      .busy(busy1), .word_done(wdone1), .ovf(ovf1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Serial receiver for dut0: sample on negedge, shift on spi_clk rise, store on spi_en rise.
   logic [15:0] cap0 = '0;
   logic [15:0] words0[$];
   int wbits0[$];
   int nbits0 = 0, rises0 = 0, en_cnt0 = 0, wd_cnt0 = 0, glitch0 = 0;
   int wrise0 = -1, efall0 = -1, wdcyc0 = -1, bfall0 = -1;
   logic pclk0 = 0, pen0 = 0, pdat0 = 0, pbusy0 = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         nbits0 = 0;
         cap0 = '0;
      end
      if (sclk0 && !pclk0) begin
         cap0 = {cap0[14:0], sdat0};
         if (nbits0 == 0) wrise0 = cyc;
         nbits0++;
         rises0++;
      end
      if (sclk0 && pclk0 && sdat0 != pdat0) glitch0++;
      if (sen0 && !pen0) begin
         words0.push_back(cap0);
         wbits0.push_back(nbits0);
         nbits0 = 0;
         en_cnt0++;
      end
      if (!sen0 && pen0) efall0 = cyc;
      if (wdone0) begin wd_cnt0++; wdcyc0 = cyc; end
      if (!busy0 && pbusy0) bfall0 = cyc;
      pclk0 = sclk0; pen0 = sen0; pdat0 = sdat0; pbusy0 = busy0;
   end

   // Receiver for dut1 also measures high-phase length, rise-to-rise period and spi_en width.
   logic [19:0] cap1 = '0, word1 = '0;
   int nbits1 = 0, wbits1 = 0, en_cnt1 = 0, wd_cnt1 = 0, glitch1 = 0;
   int hirun1 = 0, himin1 = 999, himax1 = 0, lastr1 = -1, permin1 = 999, permax1 = 0;
   int enrun1 = 0, enlen1 = 0;
   logic pclk1 = 0, pen1 = 0, pdat1 = 0;

   always @(negedge clk) begin
      if (sclk1) hirun1++;
      else if (pclk1) begin
         if (hirun1 < himin1) himin1 = hirun1;
         if (hirun1 > himax1) himax1 = hirun1;
         hirun1 = 0;
      end
      if (sclk1 && !pclk1) begin
         if (lastr1 >= 0) begin
            if (cyc - lastr1 < permin1) permin1 = cyc - lastr1;
            if (cyc - lastr1 > permax1) permax1 = cyc - lastr1;
         end
         lastr1 = cyc;
         cap1 = {cap1[18:0], sdat1};
         nbits1++;
      end
      if (sclk1 && pclk1 && sdat1 != pdat1) glitch1++;
      if (sen1) enrun1++;
      else if (pen1) begin enlen1 = enrun1; enrun1 = 0; end
      if (sen1 && !pen1) begin word1 = cap1; wbits1 = nbits1; nbits1 = 0; en_cnt1++; end
      if (wdone1) wd_cnt1++;
      pclk1 = sclk1; pen1 = sen1; pdat1 = sdat1;
   end

   // One write on dut0; acc is the index of the clock edge that accepted it.
   task automatic wr_one0(input logic [15:0] w, output int acc);
      @(negedge clk);
      if0.wr_valid = 1'b1;
      if0.wr_addr  = w[15:12];
      if0.wr_data  = w[11:0];
      @(negedge clk);
      acc = cyc;
      if0.wr_valid = 1'b0;
   endtask

   task automatic wait_en0(input int n, input int budget, input string tag);
      for (int i = 0; i < budget && en_cnt0 < n; i++) @(negedge clk);
      check(tag, 32'(en_cnt0 >= n), 32'd1);
   endtask

   logic [15:0] burst [5] = '{16'h2ABC, 16'h3123, 16'hF00F, 16'h8001, 16'h5555};
   logic [15:0] t2_exp [6] = '{16'h1111, 16'h2ABC, 16'h3123, 16'hF00F, 16'h8001, 16'h6789};

   initial begin
      int acc, base, r0, cf, gacc, afall;
      logic [4:0] rdy;
      if0.wr_valid = 1'b0; if0.wr_addr = '0; if0.wr_data = '0;
      if1.wr_valid = 1'b0; if1.wr_addr = '0; if1.wr_data = '0;
      fval0 = 1'b0; fval1 = 1'b0;

      // Reset values, then ready on the first clock after release
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_outputs", {29'd0, sclk0, sen0, sdat0}, 32'd0);
      check("rst_status", {28'd0, busy0, wdone0, ovf0, if0.wr_ready}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready_first_clk", 32'(if0.wr_ready), 32'd1);

      // Single write: 16'h73E1, timing relative to LOAD (= acc+1)
      wr_one0({REG_FT_TIMER, 12'h3E1}, acc);
      wait_en0(1, 100, "t1_done_timeout");
      repeat (5) @(negedge clk);
      check("t1_word", 32'(words0[0]), 32'h73E1);
      check("t1_bits", 32'(wbits0[0]), 32'd16);
      check("t1_first_rise", 32'(wrise0), 32'(acc + 3));
      check("t1_word_done", 32'(wdcyc0), 32'(acc + 34));
      check("t1_en_fall", 32'(efall0), 32'(acc + 35));
      check("t1_busy_fall", 32'(bfall0), 32'(acc + 36));
      check("t1_en_pulses", 32'(en_cnt0), 32'd1);
      check("t1_wd_pulses", 32'(wd_cnt0), 32'd1);
      check("t1_ovf_clear", 32'(ovf0), 32'd0);

      // Queue overflow while busy, then push-with-pop on a full queue
      base = en_cnt0;
      wr_one0(16'h1111, acc);
      repeat (4) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if0.wr_valid = 1'b1;
         if0.wr_addr  = burst[i][15:12];
         if0.wr_data  = burst[i][11:0];
         rdy[i] = if0.wr_ready;
      end
      check("t2_ready_pattern", 32'(rdy), 32'h0F);
      gacc = -1;
      afall = -1;
      for (int k = 0; k < 200 && gacc < 0; k++) begin
         @(negedge clk);
         if0.wr_addr = 4'h6;
         if0.wr_data = 12'h789;
         if (if0.wr_ready) begin gacc = cyc; afall = efall0; end
      end
      @(negedge clk);
      if0.wr_valid = 1'b0;
      check("t2_ovf", 32'(ovf0), 32'd1);
      check("t2_push_on_full", 32'(gacc), 32'(afall + 2));
      wait_en0(base + 6, 400, "t2_done_timeout");
      for (int k = 0; k < 6; k++)
         check($sformatf("t2_word%0d", k), 32'(words0[base + k]), 32'(t2_exp[k]));
      repeat (60) @(negedge clk);
      check("t2_no_extra", 32'(en_cnt0), 32'(base + 6));
      check("t2_ovf_sticky", 32'(ovf0), 32'd1);

      // fval high before writes: no activity; LOAD the cycle after fval falls
      fval0 = 1'b1;
      base = en_cnt0;
      r0 = rises0;
      wr_one0({REG_SEQUENCER, 12'hABC}, acc);
      wr_one0({REG_RES1_LENGTH, 12'hFFF}, acc);
      repeat (50) @(negedge clk);
      check("t3_no_clk", 32'(rises0), 32'(r0));
      check("t3_busy_held", 32'(busy0), 32'd1);
      @(negedge clk);
      fval0 = 1'b0;
      cf = cyc;
      for (int k = 0; k < 20 && rises0 == r0; k++) @(negedge clk);
      check("t3_start_latency", 32'(wrise0), 32'(cf + 3));
      wait_en0(base + 2, 200, "t3_done_timeout");
      check("t3_word0", 32'(words0[base]), 32'h0ABC);
      check("t3_word1", 32'(words0[base + 1]), 32'h4FFF);

      // fval rising mid-word: word completes, next one waits
      base = en_cnt0;
      wr_one0(16'h9555, acc);
      wr_one0(16'h1000, acc);
      for (int k = 0; k < 100 && nbits0 < 8; k++) @(negedge clk);
      fval0 = 1'b1;
      wait_en0(base + 1, 100, "t4_first_timeout");
      repeat (60) @(negedge clk);
      check("t4_held", 32'(en_cnt0), 32'(base + 1));
      check("t4_no_bits", 32'(nbits0), 32'd0);
      check("t4_busy", 32'(busy0), 32'd1);
      check("t4_word0", 32'(words0[base]), 32'h9555);
      fval0 = 1'b0;
      wait_en0(base + 2, 100, "t4_second_timeout");
      check("t4_word1", 32'(words0[base + 1]), 32'h1000);

      // CLK_DIV=3, 20-bit word on dut1
      @(negedge clk);
      if1.wr_valid = 1'b1;
      if1.wr_addr  = 4'hA;
      if1.wr_data  = 16'hC35A;
      @(negedge clk);
      if1.wr_valid = 1'b0;
      for (int k = 0; k < 300 && (en_cnt1 < 1 || busy1); k++) @(negedge clk);
      check("t6_en_pulses", 32'(en_cnt1), 32'd1);
      check("t6_word", 32'(word1), 32'hAC35A);
      check("t6_bits", 32'(wbits1), 32'd20);
      check("t6_hi_min", 32'(himin1), 32'd3);
      check("t6_hi_max", 32'(himax1), 32'd3);
      check("t6_period_min", 32'(permin1), 32'd6);
      check("t6_period_max", 32'(permax1), 32'd6);
      check("t6_en_len", 32'(enlen1), 32'd3);
      check("t6_wd_pulses", 32'(wd_cnt1), 32'd1);
      check("t6_busy_idle", 32'(busy1), 32'd0);
      check("dat_stable_hi", 32'(glitch0 + glitch1), 32'd0);

      // Reset mid-word with two words queued
      base = en_cnt0;
      wr_one0(16'hC0DE, acc);
      wr_one0(16'h1234, acc);
      wr_one0(16'h5678, acc);
      for (int k = 0; k < 100 && nbits0 < 5; k++) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t5_async_clear", {26'd0, sclk0, sen0, sdat0, wdone0, busy0, if0.wr_ready}, 32'd0);
      check("t5_ovf_clear", 32'(ovf0), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      r0 = rises0;
      @(negedge clk);
      check("t5_ready_after_reset", 32'(if0.wr_ready), 32'd1);
      repeat (100) @(negedge clk);
      check("t5_no_en", 32'(en_cnt0), 32'(base));
      check("t5_no_clk", 32'(rises0), 32'(r0));
      check("t5_busy", 32'(busy0), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
